// File: rtl/superleg_pkg.sv
// Shared definitions for the superleg dual-issue LEGv8 core.
// Contents: opcode constants, instruction-class and ALU-op enums,
// instruction field positions and the XZR register index.
package superleg_pkg;

  localparam logic [4:0] XZR = 5'd31;

  // Field positions within a 32-bit instruction word
  localparam int unsigned RdLsb    = 0;   // Rd / Rt
  localparam int unsigned RnLsb    = 5;
  localparam int unsigned RmLsb    = 16;
  localparam int unsigned Imm12Lsb = 10;
  localparam int unsigned Addr9Lsb = 12;
  localparam int unsigned Imm19Lsb = 5;

  // Opcodes, left-aligned at bit 31
  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [9:0]  OpAddi = 10'b1001000100;
  localparam logic [7:0]  OpCbz  = 8'b10110100;
  localparam logic [5:0]  OpB    = 6'b000101;

  typedef enum logic [2:0] {
    ClsR, ClsAddi, ClsLoad, ClsStore, ClsCbz, ClsB, ClsNop
  } inst_class_e;

  typedef enum logic [1:0] {AluAdd, AluSub, AluAnd, AluOrr} alu_op_e;

endpackage

// File: rtl/legv8_slot_decoder.sv
// One issue slot of the superleg core: decode, operand select (XZR reads as 0),
// immediate extension, ALU, memory address generation and branch resolution.
// Ports:
//   instr, slot_pc                 instruction word and its address
//   read_reg1/2, reg_data1/2       register-file read address / data
//   mem_data_in                    load data from data memory
//   write_reg, write_data, regwrite   register write request (XZR suppressed)
//   mem_address, mem_data_out, memread, memwrite   data-memory request
//   reads_rn, reads_r2             which read ports carry a real operand
//   branch_taken, branch_target    resolved control flow for this slot
module legv8_slot_decoder
  import superleg_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [63:0] slot_pc,
  output logic [4:0]  read_reg1,
  output logic [4:0]  read_reg2,
  input  logic [63:0] reg_data1,
  input  logic [63:0] reg_data2,
  input  logic [63:0] mem_data_in,
  output logic [4:0]  write_reg,
  output logic [63:0] write_data,
  output logic        regwrite,
  output logic [63:0] mem_address,
  output logic [63:0] mem_data_out,
  output logic        memread,
  output logic        memwrite,
  output logic        reads_rn,
  output logic        reads_r2,
  output logic        branch_taken,
  output logic [63:0] branch_target
);

  inst_class_e cls;
  alu_op_e     alu_op;
  logic [4:0]  rn, rm, rd;
  logic [63:0] op_a, op_b, alu_res;
  logic [63:0] imm12_z, addr9_s, cbz_off, b_off;

  always_comb begin
    cls    = ClsNop;
    alu_op = AluAdd;
    if (instr[31:21] == OpAdd) begin
      cls = ClsR;
    end else if (instr[31:21] == OpSub) begin
      cls    = ClsR;
      alu_op = AluSub;
    end else if (instr[31:21] == OpAnd) begin
      cls    = ClsR;
      alu_op = AluAnd;
    end else if (instr[31:21] == OpOrr) begin
      cls    = ClsR;
      alu_op = AluOrr;
    end else if (instr[31:21] == OpLdur) begin
      cls = ClsLoad;
    end else if (instr[31:21] == OpStur) begin
      cls = ClsStore;
    end else if (instr[31:22] == OpAddi) begin
      cls = ClsAddi;
    end else if (instr[31:24] == OpCbz) begin
      cls = ClsCbz;
    end else if (instr[31:26] == OpB) begin
      cls = ClsB;
    end
  end

  assign rd = instr[RdLsb +: 5];
  assign rn = instr[RnLsb +: 5];
  assign rm = instr[RmLsb +: 5];

  // Second read port carries Rm for R-type, Rt for everything else
  assign read_reg1 = rn;
  assign read_reg2 = (cls == ClsR) ? rm : rd;

  assign op_a = (rn == XZR)        ? 64'd0 : reg_data1;
  assign op_b = (read_reg2 == XZR) ? 64'd0 : reg_data2;

  assign imm12_z = {52'd0, instr[Imm12Lsb +: 12]};
  assign addr9_s = {{55{instr[Addr9Lsb + 8]}}, instr[Addr9Lsb +: 9]};
  assign cbz_off = {{43{instr[Imm19Lsb + 18]}}, instr[Imm19Lsb +: 19], 2'b00};
  assign b_off   = {{36{instr[25]}}, instr[25:0], 2'b00};

  always_comb begin
    unique case (alu_op)
      AluSub:  alu_res = op_a - op_b;
      AluAnd:  alu_res = op_a & op_b;
      AluOrr:  alu_res = op_a | op_b;
      default: alu_res = op_a + op_b;
    endcase
  end

  always_comb begin
    write_data = 64'd0;
    case (cls)
      ClsR:    write_data = alu_res;
      ClsAddi: write_data = op_a + imm12_z;
      ClsLoad: write_data = mem_data_in;
      default: write_data = 64'd0;
    endcase
  end

  assign write_reg = rd;
  assign regwrite  = (cls inside {ClsR, ClsAddi, ClsLoad}) && (rd != XZR);

  assign mem_address  = op_a + addr9_s;
  assign mem_data_out = op_b;
  assign memread      = (cls == ClsLoad);
  assign memwrite     = (cls == ClsStore);

  assign reads_rn = cls inside {ClsR, ClsAddi, ClsLoad, ClsStore};
  assign reads_r2 = cls inside {ClsR, ClsStore, ClsCbz};

  assign branch_taken  = (cls == ClsB) || ((cls == ClsCbz) && (op_b == 64'd0));
  assign branch_target = slot_pc + ((cls == ClsB) ? b_off : cbz_off);

endmodule

// File: rtl/superleg_dual_core.sv
// Dual-issue in-order single-cycle LEGv8 subset core. Two decoders share the
// fetch pair at PC1/PC2; pairing hazards squash slot 2 and the PC advances by 4.
// Optional feature macro: SUPERLEG_DUAL_ISSUE_EN (undefined: slot 2 is always
// squashed, single issue).
// Ports: CLOCK/RESET (async active-low), IC1/IC2 instruction words, PC1/PC2
// fetch addresses, per-slot register-file read/write ports, per-slot data-memory
// address/data/strobes.
module superleg_dual_core
  import superleg_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] IC1,
  input  logic [31:0] IC2,
  output logic [63:0] PC1,
  output logic [63:0] PC2,
  output logic [4:0]  read_reg1_1,
  output logic [4:0]  read_reg2_1,
  output logic [4:0]  read_reg1_2,
  output logic [4:0]  read_reg2_2,
  input  logic [63:0] reg_data1_1,
  input  logic [63:0] reg_data2_1,
  input  logic [63:0] reg_data1_2,
  input  logic [63:0] reg_data2_2,
  output logic [4:0]  write_reg1_1,
  output logic [4:0]  write_reg1_2,
  output logic [63:0] write_data1_1,
  output logic [63:0] write_data1_2,
  output logic        regwrite1_1,
  output logic        regwrite1_2,
  output logic [63:0] mem_address_out1,
  output logic [63:0] mem_address_out2,
  output logic [63:0] mem_data_out1,
  output logic [63:0] mem_data_out2,
  input  logic [63:0] mem_data_in1,
  input  logic [63:0] mem_data_in2,
  output logic        control_memwrite_out1,
  output logic        control_memwrite_out2,
  output logic        control_memread_out1,
  output logic        control_memread_out2
);

`ifdef SUPERLEG_DUAL_ISSUE_EN
  localparam bit DualIssue = 1'b1;
`else
  localparam bit DualIssue = 1'b0;
`endif

  logic [63:0] pc_q, pc_d;
  logic        rw_1, rw_2, mr_1, mr_2, mw_1, mw_2;
  logic        rn_used_2, r2_used_2, rn_used_1, r2_used_1;
  logic        br_1, br_2;
  logic [63:0] tgt_1, tgt_2;
  logic        raw, waw, mem_pair, squash_2;

  assign PC1 = pc_q;
  assign PC2 = pc_q + 64'd4;

  legv8_slot_decoder u_slot1 (
    .instr        (IC1),
    .slot_pc      (PC1),
    .read_reg1    (read_reg1_1),
    .read_reg2    (read_reg2_1),
    .reg_data1    (reg_data1_1),
    .reg_data2    (reg_data2_1),
    .mem_data_in  (mem_data_in1),
    .write_reg    (write_reg1_1),
    .write_data   (write_data1_1),
    .regwrite     (rw_1),
    .mem_address  (mem_address_out1),
    .mem_data_out (mem_data_out1),
    .memread      (mr_1),
    .memwrite     (mw_1),
    .reads_rn     (rn_used_1),
    .reads_r2     (r2_used_1),
    .branch_taken (br_1),
    .branch_target(tgt_1)
  );

  legv8_slot_decoder u_slot2 (
    .instr        (IC2),
    .slot_pc      (PC2),
    .read_reg1    (read_reg1_2),
    .read_reg2    (read_reg2_2),
    .reg_data1    (reg_data1_2),
    .reg_data2    (reg_data2_2),
    .mem_data_in  (mem_data_in2),
    .write_reg    (write_reg1_2),
    .write_data   (write_data1_2),
    .regwrite     (rw_2),
    .mem_address  (mem_address_out2),
    .mem_data_out (mem_data_out2),
    .memread      (mr_2),
    .memwrite     (mw_2),
    .reads_rn     (rn_used_2),
    .reads_r2     (r2_used_2),
    .branch_taken (br_2),
    .branch_target(tgt_2)
  );

  // rw_1 is already false for an XZR destination, so XZR never forms a hazard.
  // Slot 1's own read flags say nothing about pairing; fold them in harmlessly.
  assign raw = rw_1 && ((rn_used_2 && (read_reg1_2 == write_reg1_1)) ||
                        (r2_used_2 && (read_reg2_2 == write_reg1_1)));
  assign waw      = rw_1 && rw_2 && (write_reg1_1 == write_reg1_2);
  assign mem_pair = (mr_1 || mw_1) && (mr_2 || mw_2) && (rn_used_1 || r2_used_1);
  assign squash_2 = !DualIssue || br_1 || raw || waw || mem_pair;

  always_comb begin
    pc_d = pc_q + 64'd8;
    if (br_1) begin
      pc_d = tgt_1;
    end else if (squash_2) begin
      pc_d = pc_q + 64'd4;
    end else if (br_2) begin
      pc_d = tgt_2;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Enables are held low while reset is asserted
  assign regwrite1_1           = RESET && rw_1;
  assign control_memread_out1  = RESET && mr_1;
  assign control_memwrite_out1 = RESET && mw_1;
  assign regwrite1_2           = RESET && !squash_2 && rw_2;
  assign control_memread_out2  = RESET && !squash_2 && mr_2;
  assign control_memwrite_out2 = RESET && !squash_2 && mw_2;

endmodule

// File: tb/tb_superleg_dual_core.sv
module tb_superleg_dual_core;

`ifdef SUPERLEG_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic        CLOCK, RESET;
  logic [31:0] IC1, IC2;
  logic [63:0] PC1, PC2;
  logic [4:0]  read_reg1_1, read_reg2_1, read_reg1_2, read_reg2_2;
  logic [63:0] reg_data1_1, reg_data2_1, reg_data1_2, reg_data2_2;
  logic [4:0]  write_reg1_1, write_reg1_2;
  logic [63:0] write_data1_1, write_data1_2;
  logic        regwrite1_1, regwrite1_2;
  logic [63:0] mem_address_out1, mem_address_out2, mem_data_out1, mem_data_out2;
  logic [63:0] mem_data_in1, mem_data_in2;
  logic        control_memwrite_out1, control_memwrite_out2;
  logic        control_memread_out1, control_memread_out2;

  logic [63:0] rf [32];
  logic [63:0] dmem [32];
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_pc;

  superleg_dual_core #(.RESET_PC(64'h0)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .IC1(IC1), .IC2(IC2), .PC1(PC1), .PC2(PC2),
    .read_reg1_1(read_reg1_1), .read_reg2_1(read_reg2_1),
    .read_reg1_2(read_reg1_2), .read_reg2_2(read_reg2_2),
    .reg_data1_1(reg_data1_1), .reg_data2_1(reg_data2_1),
    .reg_data1_2(reg_data1_2), .reg_data2_2(reg_data2_2),
    .write_reg1_1(write_reg1_1), .write_reg1_2(write_reg1_2),
    .write_data1_1(write_data1_1), .write_data1_2(write_data1_2),
    .regwrite1_1(regwrite1_1), .regwrite1_2(regwrite1_2),
    .mem_address_out1(mem_address_out1), .mem_address_out2(mem_address_out2),
    .mem_data_out1(mem_data_out1), .mem_data_out2(mem_data_out2),
    .mem_data_in1(mem_data_in1), .mem_data_in2(mem_data_in2),
    .control_memwrite_out1(control_memwrite_out1),
    .control_memwrite_out2(control_memwrite_out2),
    .control_memread_out1(control_memread_out1),
    .control_memread_out2(control_memread_out2)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // External register file and data memory models
  assign reg_data1_1  = rf[read_reg1_1];
  assign reg_data2_1  = rf[read_reg2_1];
  assign reg_data1_2  = rf[read_reg1_2];
  assign reg_data2_2  = rf[read_reg2_2];
  assign mem_data_in1 = dmem[mem_address_out1[7:3]];
  assign mem_data_in2 = dmem[mem_address_out2[7:3]];

  always @(posedge CLOCK) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) begin
        rf[i]   <= 64'd0;
        dmem[i] <= 64'd0;
      end
      rf[1] <= 64'd3;
      rf[2] <= 64'd4;
      rf[3] <= 64'hAB;
      rf[4] <= 64'h100;
    end else begin
      if (regwrite1_1) rf[write_reg1_1] <= write_data1_1;
      if (regwrite1_2) rf[write_reg1_2] <= write_data1_2;
      if (control_memwrite_out1) dmem[mem_address_out1[7:3]] <= mem_data_out1;
      if (control_memwrite_out2) dmem[mem_address_out2[7:3]] <= mem_data_out2;
    end
  end

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rd,
                                        input logic [4:0] rn, input logic [4:0] rm);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rn,
                                           input logic [11:0] imm);
    return {10'b1001000100, imm, rn, rd};
  endfunction

  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [4:0] rt,
                                        input logic [4:0] rn, input logic [8:0] off);
    return {op, off, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] enc_cbz(input logic [4:0] rt, input logic [18:0] off);
    return {8'b10110100, off, rt};
  endfunction

  function automatic logic [31:0] enc_b(input logic [25:0] off);
    return {6'b000101, off};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] AND  = 11'b10001010000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;

  initial begin
    RESET = 1'b0;
    IC1 = enc_r(ADD, 5'd5, 5'd1, 5'd2);
    IC2 = enc_d(LDUR, 5'd7, 5'd4, 9'd0);
    tick();
    check("rst_pc1", PC1, 64'd0);
    check("rst_pc2", PC2, 64'd4);
    check("rst_rw1", 64'(regwrite1_1), 64'd0);
    check("rst_rw2", 64'(regwrite1_2), 64'd0);
    check("rst_mr2", 64'(control_memread_out2), 64'd0);

    // Two independent ADDs: X5 = 3+4, X6 = 0xAB+0x100
    IC2 = enc_r(ADD, 5'd6, 5'd3, 5'd4);
    RESET = 1'b1;
    #1;
    check("add_rw1", 64'(regwrite1_1), 64'd1);
    check("add_wd1", write_data1_1, 64'd7);
    check("add_wr1", 64'(write_reg1_1), 64'd5);
    check("add_rw2", 64'(regwrite1_2), 64'(DUAL));
    exp_pc = DUAL ? 64'd8 : 64'd4;
    tick();
    check("add_pc", PC1, exp_pc);

    // RAW: ADDI X1,XZR,#5 ; ADD X2,X1,X1
    IC1 = enc_addi(5'd1, 5'd31, 12'd5);
    IC2 = enc_r(ADD, 5'd2, 5'd1, 5'd1);
    #1;
    check("raw_wd1", write_data1_1, 64'd5);
    check("raw_rw2", 64'(regwrite1_2), 64'd0);
    exp_pc = exp_pc + 64'd4;
    tick();
    check("raw_pc", PC1, exp_pc);
    IC1 = enc_r(ADD, 5'd2, 5'd1, 5'd1);
    IC2 = 32'd0;
    #1;
    check("raw_add", write_data1_1, 64'd10);
    exp_pc = exp_pc + (DUAL ? 64'd8 : 64'd4);
    tick();
    check("nop2_pc", PC1, exp_pc);

    // STUR X3,[X4,#-8] ; LDUR X7,[X4,#-8]
    IC1 = enc_d(STUR, 5'd3, 5'd4, 9'h1F8);
    IC2 = enc_d(LDUR, 5'd7, 5'd4, 9'h1F8);
    #1;
    check("st_addr", mem_address_out1, 64'hF8);
    check("st_mw1", 64'(control_memwrite_out1), 64'd1);
    check("st_data", mem_data_out1, 64'hAB);
    check("st_mr2", 64'(control_memread_out2), 64'd0);
    exp_pc = exp_pc + 64'd4;
    tick();
    check("st_pc", PC1, exp_pc);
    IC1 = enc_d(LDUR, 5'd7, 5'd4, 9'h1F8);
    IC2 = 32'd0;
    #1;
    check("ld_mr1", 64'(control_memread_out1), 64'd1);
    check("ld_mw1", 64'(control_memwrite_out1), 64'd0);
    check("ld_wd1", write_data1_1, 64'hAB);
    exp_pc = exp_pc + (DUAL ? 64'd8 : 64'd4);
    tick();
    check("ld_pc", PC1, exp_pc);

    // WAW: ADD X10,X1,X2 ; ADDI X10,XZR,#1
    IC1 = enc_r(ADD, 5'd10, 5'd1, 5'd2);
    IC2 = enc_addi(5'd10, 5'd31, 12'd1);
    #1;
    check("waw_rw1", 64'(regwrite1_1), 64'd1);
    check("waw_rw2", 64'(regwrite1_2), 64'd0);
    exp_pc = exp_pc + 64'd4;
    tick();
    check("waw_pc", PC1, exp_pc);

    // Asynchronous reset mid-cycle, then CBZ XZR,+4 at PC 0
    RESET = 1'b0;
    #1;
    check("arst_pc", PC1, 64'd0);
    check("arst_rw1", 64'(regwrite1_1), 64'd0);
    RESET = 1'b1;
    IC1 = enc_cbz(5'd31, 19'd4);
    IC2 = enc_r(ADD, 5'd8, 5'd1, 5'd2);
    #1;
    check("cbz_rw2", 64'(regwrite1_2), 64'd0);
    tick();
    check("cbz_pc", PC1, 64'd16);

    // B -2 in slot 1 at PC 16 -> 8
    IC1 = enc_b(26'h3FFFFFE);
    IC2 = enc_r(ADD, 5'd9, 5'd1, 5'd2);
    #1;
    check("b1_rw2", 64'(regwrite1_2), 64'd0);
    tick();
    check("b1_pc", PC1, 64'd8);

    // B -1 in slot 2 at PC 8 (slot PC 12) -> 8 when dual-issued
    IC1 = enc_r(ADD, 5'd9, 5'd1, 5'd2);
    IC2 = enc_b(26'h3FFFFFF);
    #1;
    check("b2_wd1", write_data1_1, 64'd15);
    tick();
    exp_pc = DUAL ? 64'd8 : 64'd12;
    check("b2_pc", PC1, exp_pc);

    // XZR destination and NOP encodings
    IC1 = enc_r(ADD, 5'd31, 5'd1, 5'd2);
    IC2 = 32'd0;
    #1;
    check("xzr_rw1", 64'(regwrite1_1), 64'd0);
    check("xzr_rw2", 64'(regwrite1_2), 64'd0);
    IC1 = 32'd0;
    #1;
    check("nop_rw1", 64'(regwrite1_1), 64'd0);
    check("nop_mr1", 64'(control_memread_out1), 64'd0);
    check("nop_mw1", 64'(control_memwrite_out1), 64'd0);

    // ALU variety with X1=5, X2=10
    IC1 = enc_r(SUB, 5'd12, 5'd1, 5'd2);
    #1;
    check("sub_wd1", write_data1_1, 64'hFFFF_FFFF_FFFF_FFFB);
    IC1 = enc_r(AND, 5'd12, 5'd1, 5'd2);
    #1;
    check("and_wd1", write_data1_1, 64'd0);
    IC1 = enc_r(ORR, 5'd12, 5'd1, 5'd2);
    #1;
    check("orr_wd1", write_data1_1, 64'd15);
    IC1 = enc_addi(5'd11, 5'd31, 12'hFFF);
    #1;
    check("addi_zext", write_data1_1, 64'hFFF);
    IC1 = enc_r(ADD, 5'd12, 5'd31, 5'd2);
    #1;
    check("xzr_src", write_data1_1, 64'd10);

    // CBZ on nonzero X1 falls through
    IC1 = enc_cbz(5'd1, 19'd4);
    #1;
    exp_pc = exp_pc + (DUAL ? 64'd8 : 64'd4);
    tick();
    check("cbznt_pc", PC1, exp_pc);

    // PC wrap: B -1 at PC 0
    RESET = 1'b0;
    #1;
    RESET = 1'b1;
    IC1 = enc_b(26'h3FFFFFF);
    IC2 = 32'd0;
    tick();
    check("wrap_pc1", PC1, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_pc2", PC2, 64'd0);
    IC1 = 32'd0;
    tick();
    check("wrap_adv", PC1, DUAL ? 64'd4 : 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/superleg_dual_core.md
Name: superleg_dual_core

Overview:
- Dual-issue, in-order, single-cycle LEGv8 subset core. Fetches two consecutive instructions per cycle, executes both, and advances the PC by 8.
- If a pairing hazard exists, executes slot 1 only and advances the PC by 4.
- The register file (2 writes, 4 reads), the instruction cache and the dual-port data memory are external. The core drives their address, data and control and receives their combinational read data.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- IC1, IC2  in  32  instruction words at PC1 and PC2
- PC1, PC2  out  64  fetch addresses; PC2 = PC1 + 4
- read_reg1_1, read_reg2_1, read_reg1_2, read_reg2_2  out  5  register-file read addresses, per slot
- reg_data1_1, reg_data2_1, reg_data1_2, reg_data2_2  in  64  register-file read data, combinational
- write_reg1_1, write_reg1_2  out  5  write addresses
- write_data1_1, write_data1_2  out  64  write data
- regwrite1_1, regwrite1_2  out  1  write enables; the register file commits on the CLOCK rising edge
- mem_address_out1/2  out  64  data-memory address, per slot
- mem_data_out1/2  out  64  store data, per slot
- mem_data_in1/2  in  64  load data, combinational
- control_memwrite_out1/2, control_memread_out1/2  out  1  memory strobes, per slot

Behaviour:
- State: a single 64-bit PC register.
  - RESET low: PC = RESET_PC immediately.
  - While RESET is low, all regwrite and memwrite/memread outputs are 0.
- All other outputs are combinational from PC, IC1/IC2 and the read data (one-cycle latency per instruction).
- Decode, identically per slot:
  - Fields: Rd/Rt = [4:0], Rn = [9:5], Rm = [20:16].
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: Rd = Rn op Rm.
  - ADDI 1001000100: Rd = Rn + zext(imm12 [21:10]).
  - LDUR 11111000010: Rt = mem[Rn + sext(addr9 [20:12])].
  - STUR 11111000000: mem[Rn + sext(addr9)] = Rt.
  - CBZ 10110100: if Rt == 0, PC_target = slot PC + sext([23:5]) << 2.
  - B 000101: PC_target = slot PC + sext([25:0]) << 2.
  - Any other encoding is a NOP: no writes, no memory strobes.
- Read port mapping: read_reg1 = Rn; read_reg2 = Rm for R-type, Rt for STUR/CBZ.
- Register 31 is XZR:
  - Operands from register 31 read as 0.
  - Writes to register 31 are suppressed (regwrite = 0).
- Arithmetic is 64-bit modulo 2^64; no flags.
- Memory strobes: control_memread = 1 only for LDUR; control_memwrite = 1 only for STUR. Both strobes are 0 for every other instruction.
- Slot 2 is squashed (all its enables forced 0, PC += 4) when any of the following holds:
  - slot 1 is a taken branch (then PC = slot 1 target);
  - slot 2 reads slot 1's non-XZR destination (RAW);
  - both slots write the same non-XZR register (WAW);
  - both slots are memory operations.
- PC update when slot 2 is not squashed:
  - slot 2 taken branch: PC = slot 2 target (slot PC = PC+4);
  - otherwise PC += 8.
- PC wraps modulo 2^64.
- Reset asserted mid-cycle wins over any pending update.

Optional Feature:
- Macro: SUPERLEG_DUAL_ISSUE_EN.
- Defined: dual issue as specified above.
- Undefined:
  - slot 2 is permanently squashed;
  - PC += 4 per cycle (or the slot 1 branch target);
  - PC2 is still driven as PC1 + 4.

Decomposition:
- Package superleg_pkg: opcode constants, instruction-class enum (R, ADDI, LOAD, STORE, CBZ, B, NOP), field-position constants, XZR constant.
- Sub-module legv8_slot_decoder: decode, operand select and immediate extension for one slot. Instantiated twice.
- Hazard logic and the PC live in the top module.

Test Plan:
- Reset: RESET low → PC1 = 0, PC2 = 4, all enables 0. Release RESET, then two independent ADDs → PC1 = 8 after one edge, and both regwrite = 1.
- RAW pair: slot 1 ADDI X1,X31,#5; slot 2 ADD X2,X1,X1 → regwrite1_2 = 0, PC += 4. Next cycle slot 1 executes the ADD → write_data1_1 = 10.
- Load/store: slot 1 STUR X3,[X4,#-8] with X4 = 0x100 and X3 = 0xAB; slot 2 LDUR → slot 2 squashed, mem_address_out1 = 0xF8, control_memwrite_out1 = 1. Next cycle the LDUR reads 0xAB.
- Branches:
  - CBZ taken in slot 1 with offset +4 at PC 0 → PC = 16, slot 2 squashed.
  - B in slot 2 with offset -1 at PC 8 → PC = 8.
- XZR and NOP: ADD X31,X1,X2 → regwrite = 0. Opcode 0 → all strobes 0.
- Macro off: two independent ADDs → only slot 1 writes, PC += 4.
